// File: rtl/prog_counter_pkg.sv
// Shared register map and control-field layout for the programmable counter.
// Pure declarations; no logic.
package prog_counter_pkg;

  localparam logic [1:0] ADDR_COUNT = 2'd0;
  localparam logic [1:0] ADDR_LIMIT = 2'd1;
  localparam logic [1:0] ADDR_CTRL  = 2'd2;

  localparam int CTRL_DIR     = 0;
  localparam int CTRL_SAT     = 1;
  localparam int CTRL_OVF_CLR = 2;

  typedef struct packed {
    logic sat;
    logic dir;
  } ctrl_t;

endpackage

// File: rtl/prog_counter_step.sv
// Combinational next-count and boundary detection for one enabled step.
// Zero latency; no flow control.
module prog_counter_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir,
  input  logic             sat,
  output logic [WIDTH-1:0] next,
  output logic             hit,
  output logic             wrap
);

  always_comb begin
    next = data;
    hit  = 1'b0;
    wrap = 1'b0;
    if (!dir) begin
      // Above LIMIT the count runs through natural rollover without a boundary event.
      if (data == limit) begin
        hit  = 1'b1;
        wrap = !sat;
        next = sat ? limit : '0;
      end else begin
        next = data + WIDTH'(1);
      end
    end else begin
      if (data == '0) begin
        hit  = 1'b1;
        wrap = !sat;
        next = sat ? '0 : limit;
      end else begin
        next = data - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Loadable up/down counter with programmable limit, wrap/saturate, tc pulse, sticky ovf and cycle count.
// All outputs registered, one-cycle step latency; no backpressure, one register write per cycle.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [1:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             en,
  output logic [WIDTH-1:0] data,
  output logic             tc,
  output logic             ovf,
  output logic [WIDTH-1:0] cycles
);

  logic [WIDTH-1:0] limit;
  ctrl_t            ctrl;
  logic [WIDTH-1:0] step_next;
  logic             step_hit;
  logic             step_wrap;
  logic             wr_count;
  logic             wr_limit;
  logic             wr_ctrl;
  logic             do_step;

  assign wr_count = wr && (waddr == ADDR_COUNT);
  assign wr_limit = wr && (waddr == ADDR_LIMIT);
  assign wr_ctrl  = wr && (waddr == ADDR_CTRL);
  // A COUNT load suppresses the step, so neither tc nor ovf can fire on a load cycle.
  assign do_step  = en && !wr_count;

  prog_counter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .data (data),
    .limit(limit),
    .dir  (ctrl.dir),
    .sat  (ctrl.sat),
    .next (step_next),
    .hit  (step_hit),
    .wrap (step_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      data   <= RESET_VALUE;
      tc     <= 1'b0;
      ovf    <= 1'b0;
      cycles <= '0;
      limit  <= '1;
      ctrl   <= '0;
    end else begin
      cycles <= cycles + WIDTH'(1);
      tc     <= do_step && step_hit;

      if (wr_count) begin
        data <= wdata;
      end else if (en) begin
        data <= step_next;
      end

      // Set beats clear when a wrap coincides with an OVF_CLR write.
      if (do_step && step_wrap) begin
        ovf <= 1'b1;
      end else if (wr_ctrl && wdata[CTRL_OVF_CLR]) begin
        ovf <= 1'b0;
      end

      if (wr_limit) begin
        limit <= wdata;
      end
      if (wr_ctrl) begin
        ctrl.dir <= wdata[CTRL_DIR];
        ctrl.sat <= wdata[CTRL_SAT];
      end
    end
  end

endmodule

// File: tb/tb_prog_counter.sv
// Directed-vector bench for prog_counter (WIDTH=8, RESET_VALUE=0).
module tb_prog_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic       en;
  logic [7:0] data;
  logic       tc;
  logic       ovf;
  logic [7:0] cycles;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  prog_counter #(
    .WIDTH(8),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .waddr (waddr),
    .wdata (wdata),
    .en    (en),
    .data  (data),
    .tc    (tc),
    .ovf   (ovf),
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then sample 1ns later; the bench tracks the expected cycle count.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) ncyc = 0;
    else ncyc = ncyc + 1;
  endtask

  task automatic wreg(input logic [1:0] a, input logic [7:0] v);
    wr = 1'b1; waddr = a; wdata = v;
    tick();
    wr = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic t, input logic o);
    chk({tag, ".data"}, data, d);
    chk({tag, ".tc"},   tc,   t);
    chk({tag, ".ovf"},  ovf,  o);
  endtask

  initial begin
    logic [7:0] up_d [7];
    logic       up_t [7];
    logic [7:0] dn_d [4];
    logic       dn_t [4];
    logic [7:0] exp_d;

    up_d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
    up_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    dn_d = '{8'd1, 8'd0, 8'd0, 8'd0};
    dn_t = '{1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b1; wr = 1'b0; waddr = 2'd0; wdata = 8'h00; en = 1'b0;
    tick();
    reset = 1'b0;
    chk_out("rst", 8'h00, 1'b0, 1'b0);
    chk("rst.cycles", cycles, 8'd0);
    repeat (5) tick();
    chk_out("idle", 8'h00, 1'b0, 1'b0);
    chk("idle.cycles", cycles, 8'd5);

    // Default LIMIT is 0xFF: FE -> FF -> 00 with tc.
    wreg(2'd0, 8'hFE);
    en = 1'b1;
    tick(); chk_out("lim_ff.0", 8'hFF, 1'b0, 1'b0);
    tick(); chk_out("lim_ff.1", 8'h00, 1'b1, 1'b1);
    en = 1'b0;
    wreg(2'd2, 8'h04);
    chk_out("ovf_clr", 8'h00, 1'b0, 1'b0);

    // Up wrap with LIMIT=5.
    wreg(2'd1, 8'd5);
    wreg(2'd2, 8'h00);
    wreg(2'd0, 8'd0);
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_out($sformatf("upwrap.%0d", i), up_d[i], up_t[i], (i >= 5) ? 1'b1 : 1'b0);
    end
    en = 1'b0;
    tick();
    chk_out("upwrap.hold", 8'd1, 1'b0, 1'b1);

    // Down saturate; OVF_CLR in the same write clears the sticky flag.
    wreg(2'd2, 8'h07);
    chk("sat.ovf_clr", ovf, 1'b0);
    wreg(2'd1, 8'd3);
    wreg(2'd0, 8'd2);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("dnsat.%0d", i), dn_d[i], dn_t[i], 1'b0);
    end
    en = 1'b0;

    // Up wrap, LIMIT=0x10, COUNT load with en high; count runs through natural rollover.
    wreg(2'd2, 8'h00);
    wreg(2'd1, 8'h10);
    en = 1'b1;
    wreg(2'd0, 8'h80);
    chk_out("load_en", 8'h80, 1'b0, 1'b0);
    exp_d = 8'h80;
    for (int i = 0; i < 144; i++) begin
      exp_d = exp_d + 8'd1;
      tick();
      chk_out($sformatf("roll.%0d", i), exp_d, 1'b0, 1'b0);
    end
    // Boundary step coincides with OVF_CLR write: set wins.
    wreg(2'd2, 8'h04);
    chk_out("roll.wrap", 8'h00, 1'b1, 1'b1);
    en = 1'b0;
    wreg(2'd2, 8'h04);
    chk_out("clr_nowrap", 8'h00, 1'b0, 1'b0);

    // LIMIT write takes effect only from the following cycle.
    wreg(2'd0, 8'h0F);
    en = 1'b1;
    wreg(2'd1, 8'h0F);
    chk_out("lim_old", 8'h10, 1'b0, 1'b0);
    tick();
    chk_out("lim_new", 8'h11, 1'b0, 1'b0);
    en = 1'b0;

    // Address 3 write is ignored.
    wreg(2'd3, 8'hA5);
    chk_out("addr3", 8'h11, 1'b0, 1'b0);

    // LIMIT=0 wrap mode: 0 -> 0 with tc and ovf every enabled cycle, both directions.
    wreg(2'd1, 8'h00);
    wreg(2'd0, 8'h00);
    en = 1'b1;
    tick(); chk_out("lim0.up0", 8'h00, 1'b1, 1'b1);
    tick(); chk_out("lim0.up1", 8'h00, 1'b1, 1'b1);
    en = 1'b0;
    wreg(2'd2, 8'h05);
    chk("lim0.clr", ovf, 1'b0);
    en = 1'b1;
    tick(); chk_out("lim0.dn0", 8'h00, 1'b1, 1'b1);
    tick(); chk_out("lim0.dn1", 8'h00, 1'b1, 1'b1);
    chk("cycles.run", cycles, ncyc[7:0]);

    // Reset during count and COUNT write discards both.
    wr = 1'b1; waddr = 2'd0; wdata = 8'h33; reset = 1'b1;
    tick();
    reset = 1'b0; wr = 1'b0; en = 1'b0;
    chk_out("rst_mid", 8'h00, 1'b0, 1'b0);
    chk("rst_mid.cycles", cycles, 8'd0);
    wreg(2'd0, 8'hFE);
    en = 1'b1;
    tick(); chk_out("rst_lim.0", 8'hFF, 1'b0, 1'b0);
    tick(); chk_out("rst_lim.1", 8'h00, 1'b1, 1'b1);
    en = 1'b0;
    tick();
    chk("rst_lim.cycles", cycles, ncyc[7:0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
# prog_counter

Parametrised loadable up/down counter with a programmable terminal limit, wrap-or-saturate mode, terminal-count pulse, sticky overflow flag and a free-running cycle counter. It replaces the fixed 8-bit loadable counter as the general counting primitive for timer, event-count and pacing functions. Software or a host FSM configures it through a small write-only register port (wr/waddr/wdata).

## Interface
- WIDTH, 8, counter/limit/data width in bits; legal range 4..32.
- RESET_VALUE, 0, value of data after reset.

- clk  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr  input  1  register write strobe, one write per asserted cycle.
- waddr  input  2  register select: 0 COUNT, 1 LIMIT, 2 CTRL, 3 reserved.
- wdata  input  WIDTH  write data.
- en  input  1  count enable; one step per cycle while high.
- data  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered).
- ovf  output  1  sticky wrap flag (registered).
- cycles  output  WIDTH  free-running cycle count (registered).

## Operation
- Registers: COUNT (load data), LIMIT (terminal value, reset all-ones), CTRL (reset 0): bit0 DIR (0 up, 1 down), bit1 SAT (0 wrap, 1 saturate), bit2 OVF_CLR (write-1 pulse, not stored). CTRL bits above 2 ignored. Writes to address 3 ignored.
- Priority per cycle: reset > COUNT write > enabled step > hold.
- COUNT write with en high: load wins, no step, no tc, no ovf that cycle.
- LIMIT/CTRL write: step in the same cycle uses old LIMIT/CTRL; new values apply from next cycle.
- Up step: data < LIMIT -> data+1. data == LIMIT -> wrap: 0, tc, ovf set; sat: hold LIMIT, tc. data > LIMIT -> data+1 modulo 2^WIDTH, no tc/ovf (counts through natural rollover to 0, then to LIMIT).
- Down step: data > 0 -> data-1. data == 0 -> wrap: LIMIT, tc, ovf set; sat: hold 0, tc.
- Saturate mode at boundary: tc pulses every enabled cycle; ovf never set.
- ovf: set on any wrap step; cleared by reset or CTRL write with bit2=1; simultaneous set and clear -> set wins.
- LIMIT = 0, wrap mode: up and down both step 0 -> 0 every enabled cycle with tc and ovf each cycle.
- cycles: increments every non-reset cycle regardless of en/wr, wraps modulo 2^WIDTH, never written.
- All arithmetic unsigned, WIDTH bits, no carry-out port.

## Timing
- Reset (sampled at edge): data=RESET_VALUE, tc=0, ovf=0, cycles=0, LIMIT=all-ones, CTRL=0 after that edge. Reset mid-count or mid-write discards the operation.
- COUNT write at edge N: data=wdata after edge N.
- Step latency: 1 cycle; data, tc and ovf all update on the same edge as the boundary step (tc high for exactly the cycle after that edge).
- tc never high two consecutive cycles in wrap mode unless LIMIT = 0.
- No combinational path from any input to any output.

## Structure
- Package prog_counter_pkg: register address constants (ADDR_COUNT=0, ADDR_LIMIT=1, ADDR_CTRL=2), CTRL bit indices (CTRL_DIR=0, CTRL_SAT=1, CTRL_OVF_CLR=2), ctrl struct/typedef {dir, sat}.
- One sub-module natural: prog_counter_step — combinational next-value/boundary logic (inputs data, limit, dir, sat; outputs next, hit, wrap), instanced once; register file, ovf and cycles stay in the top.

## Test plan
- Reset then 5 idle cycles -> data=0, tc=0, ovf=0, cycles=5, LIMIT reads back via behaviour as 0xFF (count 0xFE->0xFF->0 with tc).
- LIMIT=5, up wrap, en high 7 cycles from 0 -> data 1,2,3,4,5,0,1; tc high only the cycle data=0; ovf=1 and stays after en drops.
- CTRL=DIR|SAT, LIMIT=3, COUNT=2, en 4 cycles -> data 1,0,0,0; tc high on the two cycles holding at 0 after a boundary step; ovf=0.
- COUNT write 0x80 with en high, LIMIT=0x10 up wrap -> data 0x80, then 0x81...0xFF,0x00...0x10,0x00; tc/ovf only at 0x10->0x00.
- At wrap cycle also write CTRL with bit2=1 -> ovf=1 (set wins); next CTRL write bit2=1 with no wrap -> ovf=0.
- Assert reset mid-count with wr=1 waddr=0 wdata=0x33 same cycle -> data=RESET_VALUE, cycles=0, LIMIT restored to 0xFF.
